// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: turns step/direction commands into A/B quadrature
// edges spaced DWELL_CYCLES clocks apart and tracks the net edge count as a signed position.
module quad_encoder_emulator #(
    parameter int COUNT_W      = 16,
    parameter int POS_W        = 16,
    parameter int DWELL_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [COUNT_W-1:0] cmd_count,
    input  logic               abort,
    output logic               enc_ch_a,
    output logic               enc_ch_b,
    output logic               busy,
    output logic               done,
    output logic [POS_W-1:0]   position
);

    localparam int DW_W = 16;
    localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EDGE, DWELL, FINISH} state_t;

    state_t                    state_q, state_d;
    logic                      dir_q, dir_d;
    logic [COUNT_W-1:0]        rem_q, rem_d;
    logic [DW_W-1:0]           dwell_q, dwell_d;
    logic [1:0]                phase_q, phase_d;
    logic signed [POS_W-1:0]   pos_q, pos_d;
    logic                      ready_q, ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      accept;

    // Phase order (A,B) going up: 00 -> 10 -> 11 -> 01 -> 00; down walks it backwards.
    function automatic logic [1:0] next_phase(input logic [1:0] p, input logic up);
        logic [1:0] n;
        case (p)
            2'b00:   n = up ? 2'b10 : 2'b01;
            2'b10:   n = up ? 2'b11 : 2'b00;
            2'b11:   n = up ? 2'b01 : 2'b10;
            default: n = up ? 2'b00 : 2'b11;
        endcase
        return n;
    endfunction

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        dwell_d = dwell_q;
        phase_d = phase_q;
        pos_d   = pos_q;
        // ready_q is only ever high while the FSM sits in IDLE
        accept  = cmd_valid & ready_q & ~abort;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    dir_d   = cmd_dir;
                    rem_d   = cmd_count;
                    state_d = (cmd_count != '0) ? EDGE : FINISH;
                end
            end
            EDGE: begin
                phase_d = next_phase(phase_q, dir_q);
                pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                rem_d   = rem_q - COUNT_W'(1);
                dwell_d = DWELL_LOAD;
                state_d = DWELL;
                if (abort) begin
                    rem_d   = '0;
                    state_d = FINISH;
                end
            end
            DWELL: begin
                dwell_d = dwell_q - DW_W'(1);
                if (abort) begin
                    rem_d   = '0;
                    dwell_d = '0;
                    state_d = FINISH;
                end else if (dwell_q == DW_W'(1)) begin
                    // Counter reaches 0 this cycle: EDGE plus dwell spans DWELL_CYCLES clocks.
                    state_d = (rem_q != '0) ? EDGE : FINISH;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_q == IDLE) && (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            dwell_q <= '0;
            phase_q <= 2'b00;
            pos_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            dwell_q <= dwell_d;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign enc_ch_a  = phase_q[1];
    assign enc_ch_b  = phase_q[0];
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator: table of commands with hand-computed end states,
// plus abort, reset, loopback-decoder and small-width wrap sequences.
module tb_quad_encoder_emulator;

    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst_n, cmd_valid, cmd_dir, abort;
    logic [15:0] cmd_count;
    logic        cmd_ready, enc_a, enc_b, busy, done;
    logic [15:0] position;

    logic        s_valid, s_dir;
    logic [3:0]  s_count;
    logic        s_ready, s_a, s_b, s_busy, s_done;
    logic [3:0]  s_pos;
    logic        s_abort = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [1:0]  mphase;
    logic [15:0] mpos;

    logic [1:0]  dec_prev;
    logic [15:0] dec_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    quad_encoder_emulator #(.COUNT_W(16), .POS_W(16), .DWELL_CYCLES(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_count(cmd_count), .abort(abort),
        .enc_ch_a(enc_a), .enc_ch_b(enc_b), .busy(busy), .done(done), .position(position));

    quad_encoder_emulator #(.COUNT_W(4), .POS_W(4), .DWELL_CYCLES(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .cmd_valid(s_valid), .cmd_ready(s_ready),
        .cmd_dir(s_dir), .cmd_count(s_count), .abort(s_abort),
        .enc_ch_a(s_a), .enc_ch_b(s_b), .busy(s_busy), .done(s_done), .position(s_pos));

    function automatic logic [1:0] step(input logic [1:0] p, input logic up);
        case (p)
            2'b00:   return up ? 2'b10 : 2'b01;
            2'b10:   return up ? 2'b11 : 2'b00;
            2'b11:   return up ? 2'b01 : 2'b10;
            default: return up ? 2'b00 : 2'b11;
        endcase
    endfunction

    // Reference quadrature decoder watching the DUT channels
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_prev <= 2'b00;
            dec_cnt  <= 16'd0;
        end else begin
            if ({enc_a, enc_b} == step(dec_prev, 1'b1))      dec_cnt <= dec_cnt + 16'd1;
            else if ({enc_a, enc_b} == step(dec_prev, 1'b0)) dec_cnt <= dec_cnt - 16'd1;
            dec_prev <= {enc_a, enc_b};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input logic d, input int n, output int t_pres, output bit ok);
        ok = 1'b0;
        t_pres = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                cmd_valid = 1'b1;
                cmd_dir   = d;
                cmd_count = 16'(n);
                t_pres    = cyc;
                ok        = 1'b1;
            end
        end
        if (!ok) check("ready wait", 32'd0, 32'd1);
        else begin
            @(negedge clk);
            cmd_valid = 1'b0;
            check("ready drops", 32'(cmd_ready), 32'd0);
        end
    endtask

    task automatic run_cmd(input logic d, input int n);
        int t0, last, nedge;
        bit ok, got_done;
        logic [1:0] prev;
        send(d, n, t0, ok);
        if (!ok) return;
        prev = {enc_a, enc_b};
        check("phase before edge", 32'(prev), 32'(mphase));
        nedge = 0;
        last = t0;
        got_done = 1'b0;
        for (int i = 0; i < (n + 2) * DW + 10 && !got_done; i++) begin
            @(negedge clk);
            if ({enc_a, enc_b} !== prev) begin
                nedge++;
                mphase = step(mphase, d);
                mpos   = d ? mpos + 16'd1 : mpos - 16'd1;
                check("edge value", 32'({enc_a, enc_b}), 32'(mphase));
                check("edge spacing", 32'(cyc - last), (nedge == 1) ? 32'd2 : 32'(DW));
                check("edge position", 32'(position), 32'(mpos));
                last = cyc;
                prev = {enc_a, enc_b};
            end
            if (done) begin
                got_done = 1'b1;
                check("done timing", 32'(cyc - last), (n == 0) ? 32'd2 : 32'(DW));
            end
        end
        check("done seen", 32'(got_done), 32'd1);
        check("edge count", 32'(nedge), 32'(n));
        @(negedge clk);
        check("done single pulse", 32'(done), 32'd0);
        check("ready after done", 32'(cmd_ready), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset enc", 32'({enc_a, enc_b}), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset position", 32'(position), 32'd0);
        check("reset ready", 32'(cmd_ready), 32'd1);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mphase = 2'b00;
        mpos = 16'd0;
    endtask

    typedef struct {
        logic        dir;
        int          count;
        logic [1:0]  exp_phase;
        logic [15:0] exp_pos;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t0, e5, ta, td, extra, nedge, k, tl;
        bit ok;
        logic [1:0] prev, sphase;

        vecs[0] = '{1'b1, 4, 2'b00, 16'd4};
        vecs[1] = '{1'b0, 3, 2'b10, 16'd1};
        vecs[2] = '{1'b1, 1, 2'b11, 16'd2};
        vecs[3] = '{1'b1, 0, 2'b11, 16'd2};
        vecs[4] = '{1'b0, 7, 2'b01, 16'hFFFB};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_count = 16'd0; abort = 1'b0;
        s_valid = 1'b0; s_dir = 1'b0; s_count = 4'd0;
        mphase = 2'b00; mpos = 16'd0;
        repeat (2) @(negedge clk);
        check("init enc", 32'({enc_a, enc_b}), 32'd0);
        check("init ready", 32'(cmd_ready), 32'd1);
        check("init busy", 32'(busy), 32'd0);
        check("init done", 32'(done), 32'd0);
        check("init position", 32'(position), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_cmd(vecs[v].dir, vecs[v].count);
            check("table phase", 32'({enc_a, enc_b}), 32'(vecs[v].exp_phase));
            check("table position", 32'(position), 32'(vecs[v].exp_pos));
        end

        // abort while idle must block the accept
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_count = 16'd5; abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle abort busy", 32'(busy), 32'd0);
            check("idle abort done", 32'(done), 32'd0);
        end
        cmd_valid = 1'b0; abort = 1'b0;

        // reset in the middle of a dwell
        send(1'b1, 10, t0, ok);
        nedge = 0;
        prev = {enc_a, enc_b};
        for (int i = 0; i < 4 * DW && nedge < 2; i++) begin
            @(negedge clk);
            if ({enc_a, enc_b} !== prev) begin
                nedge++;
                prev = {enc_a, enc_b};
            end
        end
        repeat (3) @(negedge clk);
        check("busy before reset", 32'(busy), 32'd1);
        check("enc nonzero before reset", 32'({enc_a, enc_b} != 2'b00), 32'd1);
        pulse_reset();
        @(negedge clk);
        check("ready after reset", 32'(cmd_ready), 32'd1);
        check("busy after reset", 32'(busy), 32'd0);

        run_cmd(1'b0, 3);
        check("down3 position", 32'(position), 32'hFFFD);
        check("down3 phase", 32'({enc_a, enc_b}), 32'b10);
        run_cmd(1'b1, 1);
        check("up1 phase", 32'({enc_a, enc_b}), 32'b11);

        // abort during dwell after the 5th edge of a long command
        pulse_reset();
        send(1'b1, 100, t0, ok);
        nedge = 0; e5 = 0;
        prev = {enc_a, enc_b};
        for (int i = 0; i < 7 * DW && nedge < 5; i++) begin
            @(negedge clk);
            if ({enc_a, enc_b} !== prev) begin
                nedge++;
                prev = {enc_a, enc_b};
                e5 = cyc;
            end
        end
        check("edges before abort", 32'(nedge), 32'd5);
        repeat (3) @(negedge clk);
        abort = 1'b1; cmd_valid = 1'b1; cmd_count = 16'd7;
        ta = cyc; td = 0; extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            abort = 1'b0;
            if (done) td = cyc;
            if ({enc_a, enc_b} !== prev) extra++;
            if (i == 1) cmd_valid = 1'b0;
        end
        check("abort done timing", 32'(td - ta), 32'd2);
        for (int i = 0; i < 2 * DW; i++) begin
            @(negedge clk);
            if ({enc_a, enc_b} !== prev) extra++;
            if (busy) extra++;
        end
        check("no activity after abort", 32'(extra), 32'd0);
        check("abort position", 32'(position), 32'd5);
        check("abort phase", 32'({enc_a, enc_b}), 32'b10);
        mphase = 2'b10; mpos = 16'd5;

        // random commands against the reference decoder
        for (int i = 0; i < 50; i++)
            run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
        repeat (3) @(negedge clk);
        check("loopback decoder", 32'(dec_cnt), 32'(position));
        check("loopback model", 32'(position), 32'(mpos));

        // narrow instance: max count, min dwell, position wrap 0x7 -> 0x8
        sphase = 2'b00; k = 0; tl = 0; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                s_valid = 1'b1; s_dir = 1'b1; s_count = 4'd15; tl = cyc; ok = 1'b1;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        prev = {s_a, s_b};
        td = 0;
        for (int i = 0; i < 60 && td == 0; i++) begin
            @(negedge clk);
            if ({s_a, s_b} !== prev) begin
                k++;
                sphase = step(sphase, 1'b1);
                check("small edge value", 32'({s_a, s_b}), 32'(sphase));
                check("small edge spacing", 32'(cyc - tl), 32'd2);
                if (k == 7) check("small pos 7", 32'(s_pos), 32'h7);
                if (k == 8) check("small pos wrap", 32'(s_pos), 32'h8);
                tl = cyc;
                prev = {s_a, s_b};
            end
            if (s_done) td = cyc;
        end
        check("small edge count", 32'(k), 32'd15);
        check("small final pos", 32'(s_pos), 32'hF);
        check("small done timing", 32'(td - tl), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
